// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: instruction word layout, control-unit
// opcodes and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int INSTR_W  = 16;
  localparam int HALT_BIT = 15;
  localparam int FUNC_MSB = 14;
  localparam int FUNC_LSB = 12;
  localparam int RX_MSB   = 11;
  localparam int RX_LSB   = 8;
  localparam int RY_MSB   = 7;
  localparam int RY_LSB   = 4;
  localparam int DATA_MSB = 3;
  localparam int DATA_LSB = 0;

  localparam logic [2:0] FUNC_LOAD = 3'b000;
  localparam logic [2:0] FUNC_MOVE = 3'b001;
  localparam logic [2:0] FUNC_ADD  = 3'b010;
  localparam logic [2:0] FUNC_SUB  = 3'b011;

  typedef struct packed {
    logic       halt;
    logic [2:0] func;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [3:0] data;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_MEM  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] word);
    instr_t r;
    r.halt = word[HALT_BIT];
    r.func = word[FUNC_MSB:FUNC_LSB];
    r.rx   = word[RX_MSB:RX_LSB];
    r.ry   = word[RY_MSB:RY_LSB];
    r.data = word[DATA_MSB:DATA_LSB];
    return r;
  endfunction

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// Down-counting watchdog for the WAIT_DONE phase: loaded on issue, counts down while
// enabled, and flags expiry on the last allowed waiting cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  // Loading TIMEOUT-1 makes the TIMEOUT-th enabled cycle the one that sees zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= LOAD_VAL;
      armed_q <= 1'b1;
    end else if (en_i && armed_q && (cnt_q != '0)) begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign expire_o = armed_q && en_i && (cnt_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issuer: fetches words from a synchronous instruction memory and hands
// each one to the control unit with w high until done, trapping on a stalled unit.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [2:0]        func,
  output logic [3:0]        rx,
  output logic [3:0]        ry,
  output logic [3:0]        data,
  output logic              w,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [7:0]        instr_count
);

  // state      | meaning
  // IDLE       | out of reset, waiting for start
  // FETCH      | imem_addr holds pc, memory samples it this cycle
  // WAIT_MEM   | memory word valid, captured at the end of the cycle
  // ISSUE      | w high, fields presented, watchdog loaded
  // WAIT_DONE  | w high, waiting for done or watchdog expiry
  // HALT       | halt word or end of memory reached
  // ERR        | watchdog expired, timeout_err sticky

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func_q;
  logic [3:0]        rx_q;
  logic [3:0]        ry_q;
  logic [3:0]        data_q;
  logic              w_q;
  logic              busy_q;
  logic              halted_q;
  logic              terr_q;
  logic [7:0]        count_q;

  instr_t word;
  logic   wd_load;
  logic   wd_en;
  logic   wd_clear;
  logic   wd_expire;

  assign word     = unpack_instr(imem_rdata);
  assign wd_load  = (state_q == ST_ISSUE);
  assign wd_en    = (state_q == ST_WAIT_DONE);
  assign wd_clear = wd_en && done;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (wd_clear),
    .load_i   (wd_load),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      func_q   <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      data_q   <= '0;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      terr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT, ST_ERR: begin
          if (start) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            terr_q   <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          addr_q  <= pc_q;
          state_q <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          // A halt word is never issued, so the fields keep the last issued values.
          if (word.halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            state_q <= ST_ISSUE;
            func_q  <= word.func;
            rx_q    <= word.rx;
            ry_q    <= word.ry;
            data_q  <= word.data;
            w_q     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done) begin
            w_q     <= 1'b0;
            count_q <= count_q + 8'd1;
            if (pc_q == PC_LAST) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              pc_q    <= pc_q + 1'b1;
              addr_q  <= pc_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end else if (wd_expire) begin
            state_q <= ST_ERR;
            w_q     <= 1'b0;
            terr_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          w_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = addr_q;
  assign func        = func_q;
  assign rx          = rx_q;
  assign ry          = ry_q;
  assign data        = data_q;
  assign w           = w_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = terr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a 16-word and a 4-word instance, each checked every cycle
// against a program-level model, plus hand-computed end-of-scenario expectations.
module tb_instr_sequencer;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-word instance
  logic        start4 = 1'b0, done4 = 1'b0;
  logic [3:0]  addr4;
  logic [15:0] rdata4 = '0;
  logic [2:0]  func4;
  logic [3:0]  rx4, ry4, data4;
  logic        w4, busy4, halted4, terr4;
  logic [7:0]  count4;
  logic [15:0] mem4 [16];

  // 4-word instance
  logic        start2 = 1'b0, done2 = 1'b0;
  logic [1:0]  addr2;
  logic [15:0] rdata2 = '0;
  logic [2:0]  func2;
  logic [3:0]  rx2, ry2, data2;
  logic        w2, busy2, halted2, terr2;
  logic [7:0]  count2;
  logic [15:0] mem2 [4];

  instr_sequencer #(.ADDR_W(4), .TIMEOUT(TIMEOUT)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .imem_addr(addr4), .imem_rdata(rdata4),
    .func(func4), .rx(rx4), .ry(ry4), .data(data4), .w(w4), .done(done4),
    .busy(busy4), .halted(halted4), .timeout_err(terr4), .instr_count(count4));

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .imem_addr(addr2), .imem_rdata(rdata2),
    .func(func2), .rx(rx2), .ry(ry2), .data(data2), .w(w2), .done(done2),
    .busy(busy2), .halted(halted2), .timeout_err(terr2), .instr_count(count2));

  always @(posedge clk) rdata4 <= mem4[addr4];
  always @(posedge clk) rdata2 <= mem2[addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level model: running flag, position inside the current instruction slot,
  // number of cycles spent waiting for done.
  typedef struct {
    bit         run;
    int         pos;
    int         pc;
    int         wcnt;
    bit         w;
    bit         halted;
    bit         terr;
    int         count;
    logic [2:0] func;
    logic [3:0] rx, ry, data;
  } model_t;

  function automatic model_t step(model_t s, bit r, bit st, bit dn, logic [15:0] word, int depth);
    model_t n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (!s.run) begin
      if (st) begin
        n.run = 1; n.pos = 0; n.pc = 0; n.count = 0; n.terr = 0; n.halted = 0;
      end
    end else begin
      case (s.pos)
        0: n.pos = 1;
        1: begin
          if (word[15]) begin
            n.run = 0; n.halted = 1;
          end else begin
            n.func = word[14:12]; n.rx = word[11:8]; n.ry = word[7:4]; n.data = word[3:0];
            n.w = 1; n.pos = 2;
          end
        end
        2: begin n.pos = 3; n.wcnt = 0; end
        default: begin
          if (dn) begin
            n.w = 0;
            n.count = (s.count + 1) % 256;
            if (s.pc == depth - 1) begin
              n.run = 0; n.halted = 1;
            end else begin
              n.pc = s.pc + 1; n.pos = 0;
            end
          end else begin
            n.wcnt = s.wcnt + 1;
            if (n.wcnt == TIMEOUT) begin
              n.run = 0; n.w = 0; n.terr = 1;
            end
          end
        end
      endcase
    end
    return n;
  endfunction

  model_t m4 = '{default: 0};
  model_t m2 = '{default: 0};
  bit     mvalid = 0;

  always @(posedge clk) begin
    if (rst) mvalid = 1;
    m4 = step(m4, rst, start4, done4, mem4[m4.pc], 16);
    m2 = step(m2, rst, start2, done2, mem2[m2.pc], 4);
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("d4.w", w4, m4.w);           chk("d4.busy", busy4, m4.run);
      chk("d4.halted", halted4, m4.halted); chk("d4.terr", terr4, m4.terr);
      chk("d4.count", count4, m4.count); chk("d4.addr", addr4, m4.pc);
      chk("d4.fields", {func4, rx4, ry4, data4}, {m4.func, m4.rx, m4.ry, m4.data});
      chk("d2.w", w2, m2.w);           chk("d2.busy", busy2, m2.run);
      chk("d2.halted", halted2, m2.halted); chk("d2.terr", terr2, m2.terr);
      chk("d2.count", count2, m2.count); chk("d2.addr", addr2, m2.pc);
      chk("d2.fields", {func2, rx2, ry2, data2}, {m2.func, m2.rx, m2.ry, m2.data});
    end
  end

  // Responders: done is raised when w has been high for resp+1 sampled cycles.
  int resp4 = -1, resp2 = -1, hi4 = 0, hi2 = 0;
  always @(negedge clk) begin
    if (w4) hi4++; else hi4 = 0;
    if (w2) hi2++; else hi2 = 0;
    done4 = (resp4 > 0) && w4 && (hi4 == resp4 + 1);
    done2 = (resp2 > 0) && w2 && (hi2 == resp2 + 1);
  end

  // Issue recorders: word presented on each w rise, and the longest w-high run.
  logic [15:0] rec4[$], rec2[$];
  int run4 = 0, maxrun4 = 0, run2 = 0;
  always @(negedge clk) begin
    if (w4) begin
      if (run4 == 0) rec4.push_back({1'b0, func4, rx4, ry4, data4});
      run4++;
      if (run4 > maxrun4) maxrun4 = run4;
    end else run4 = 0;
    if (w2) begin
      if (run2 == 0) rec2.push_back({1'b0, func2, rx2, ry2, data2});
      run2++;
    end else run2 = 0;
  end

  task automatic pulse4();
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
  endtask

  // kind 0: halted, 1: timeout_err, 2: second instruction on the bus
  task automatic wait4(input string nm, input int budget, input int kind);
    int c = 0;
    bit hit = 0;
    while (!hit && c < budget) begin
      hit = (kind == 0) ? halted4 : (kind == 1) ? terr4 : (count4 == 8'd1 && w4);
      if (!hit) begin @(negedge clk); c++; end
    end
    if (!hit) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h8000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h8000;
    repeat (2) @(negedge clk);
    chk("rst.w", w4, 0); chk("rst.busy", busy4, 0); chk("rst.count", count4, 0);
    chk("rst.addr", addr4, 0); chk("rst.halted", halted4, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two-instruction program
    mem4[0] = 16'h0018; mem4[1] = 16'h0109; mem4[2] = 16'h8000;
    resp4 = 2; rec4.delete();
    pulse4();
    wait4("prog2.halt_wait", 100, 0);
    chk("prog2.count", count4, 2); chk("prog2.halted", halted4, 1);
    chk("prog2.issued", rec4.size(), 2);
    if (rec4.size() == 2) begin
      chk("prog2.instr0", rec4[0], 16'h0018); chk("prog2.instr1", rec4[1], 16'h0109);
    end

    // Slow responder, ADD r0,r1
    mem4[0] = 16'h2010; mem4[1] = 16'h8000;
    resp4 = 10; rec4.delete(); maxrun4 = 0;
    pulse4();
    wait4("slow.halt_wait", 100, 0);
    chk("slow.w_cycles", maxrun4, 11); chk("slow.terr", terr4, 0);
    chk("slow.count", count4, 1);
    if (rec4.size() == 1) chk("slow.instr", rec4[0], 16'h2010);
    else chk("slow.issued", rec4.size(), 1);

    // Watchdog expiry: ISSUE cycle plus TIMEOUT waiting cycles with w high
    mem4[0] = 16'h0018;
    resp4 = -1; maxrun4 = 0;
    pulse4();
    wait4("wd.err_wait", 100, 1);
    chk("wd.w_cycles", maxrun4, 16); chk("wd.w", w4, 0);
    chk("wd.busy", busy4, 0); chk("wd.terr", terr4, 1);
    mem4[0] = 16'h8000; resp4 = 2;
    pulse4();
    chk("wd.restart_terr", terr4, 0); chk("wd.restart_busy", busy4, 1);
    chk("wd.restart_addr", addr4, 0);
    wait4("wd.halt_wait", 100, 0);

    // Reset while the second instruction waits for done
    mem4[0] = 16'h0109; mem4[1] = 16'h3218; mem4[2] = 16'h8000;
    resp4 = 1;
    pulse4();
    wait4("rstmid.issue_wait", 100, 2);
    resp4 = -1;
    repeat (2) @(negedge clk);
    chk("rstmid.w_before", w4, 1); chk("rstmid.data_before", data4, 4'h8);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rstmid.w", w4, 0); chk("rstmid.busy", busy4, 0); chk("rstmid.count", count4, 0);
    chk("rstmid.fields", {func4, rx4, ry4, data4}, 15'h0); chk("rstmid.addr", addr4, 0);
    @(negedge clk);

    // End of memory on the 4-word instance, with a start pulse while busy
    mem2[0] = 16'h1123; mem2[1] = 16'h0045; mem2[2] = 16'h2300; mem2[3] = 16'h3ABC;
    resp2 = 1; rec2.delete();
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (!halted2 && cyc < 100) begin
      start2 = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start2 = 1'b0;
    chk("eom.cycles", cyc, 16); chk("eom.count", count2, 4);
    chk("eom.addr", addr2, 3); chk("eom.halted", halted2, 1);
    chk("eom.issued", rec2.size(), 4);
    if (rec2.size() == 4) chk("eom.instr3", rec2[3], 16'h3ABC);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction issuer that sits upstream of the processor control unit and is the driving end of its func/rx/ry/data/w instruction interface. It fetches 16-bit instruction words from a synchronous instruction memory and presents each one to the control unit with w asserted. It holds the instruction until the control unit returns done, then advances the PC. A watchdog traps a control unit that never completes.

Parameters:
ADDR_W, 4, instruction-memory address width; the program occupies addresses 0..2^ADDR_W-1.
TIMEOUT, 15, maximum number of WAIT_DONE cycles without done before the error trap.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  pulse; begins execution at PC=0 from IDLE, HALT or ERR.
imem_addr  output  ADDR_W  instruction-memory address (registered).
imem_rdata  input  16  instruction word, valid 1 cycle after imem_addr.
func  output  3  opcode to the control unit.
rx  output  4  destination register index.
ry  output  4  source register index.
data  output  4  immediate for load.
w  output  1  instruction valid to the control unit.
done  input  1  control unit completion pulse.
busy  output  1  high in FETCH, WAIT_MEM, ISSUE, WAIT_DONE.
halted  output  1  high in HALT.
timeout_err  output  1  sticky watchdog flag; cleared only by rst or start.
instr_count  output  8  number of instructions completed since start; wraps at 255->0.

Behaviour:
- Instruction word fields: [15] halt, [14:12] func, [11:8] rx, [7:4] ry, [3:0] data. The sequencer does not interpret func.
- Reset (sync, rst=1 at a clock edge):
  - state=IDLE, pc=0, imem_addr=0.
  - func/rx/ry/data=0, w=0, busy=0, halted=0, timeout_err=0, instr_count=0.
  - rst takes priority over every other input and aborts any operation in progress; w is low on the first edge with rst.
- States:
  - IDLE: start=1 -> FETCH, pc=0, instr_count=0, timeout_err=0.
  - FETCH: imem_addr<=pc -> WAIT_MEM.
  - WAIT_MEM: one-cycle memory latency. On the next edge the instruction register captures imem_rdata.
    - halt bit=1 -> HALT.
    - otherwise -> ISSUE.
  - ISSUE: w=1 and fields driven from the instruction register; watchdog cleared -> WAIT_DONE. done is ignored in ISSUE.
  - WAIT_DONE: w stays 1; fields stay stable.
    - done=1 -> w=0 on the next edge, instr_count+1, then:
      - pc was 2^ADDR_W-1 -> HALT (no wrap).
      - otherwise pc+1 -> FETCH.
    - No done after TIMEOUT cycles in WAIT_DONE -> ERR, w=0, timeout_err=1.
    - done on the same cycle the watchdog expires counts as completion (done wins).
  - HALT: halted=1, w=0. start -> restart as from IDLE.
  - ERR: w=0, timeout_err held. start -> restart (clears timeout_err).
- start is ignored while busy=1.
- done outside WAIT_DONE is ignored.
- func/rx/ry/data hold the last issued values whenever w=0.
- Minimum issue cadence is 4 cycles per instruction when done returns on the first WAIT_DONE cycle: FETCH, WAIT_MEM, ISSUE, WAIT_DONE.

Decomposition:
- Shared package:
  - Instruction-field bit positions and the 16-bit instruction width.
  - func opcode constants: LOAD=000, MOVE=001, ADD=010, SUB=011.
  - State encoding, also used by control's curr_state debug.
- Sub-module: seq_watchdog, a down-counter with load/clear and an expire output.
- Everything else stays flat in instr_sequencer.

Test Plan:
- Reset mid-WAIT_DONE:
  - Stimulus: assert rst for 1 cycle while w=1.
  - Required: next edge w=0, state=IDLE, pc=0, instr_count=0, all fields 0.
- Two-instruction program:
  - Stimulus: mem[0]=0x0018 (LOAD r0,8), mem[1]=0x0109 (LOAD r1,9), mem[2]=0x8000; start; done returned 2 cycles after each w rise.
  - Required: w sees func=000,rx=0,data=8 then rx=1,data=9; halted=1; instr_count=2.
- Fields hold under a slow responder:
  - Stimulus: ADD instruction 0x2010; done delayed 10 cycles.
  - Required: w high and func=010, rx=0, ry=1 stable for all 11 cycles; no timeout.
- Watchdog expiry:
  - Stimulus: done never asserted.
  - Required: exactly TIMEOUT=15 cycles in WAIT_DONE, then w=0, timeout_err=1, busy=0.
  - Then: start clears timeout_err and refetches address 0.
- End of memory:
  - Stimulus: ADDR_W=2, no halt bits, done always returned.
  - Required: 4 instructions issued, then HALT with instr_count=4, pc not wrapped.
  - Also: start pulsed while busy is ignored.
